// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU widths and register constants
package cpu_pkg;

  localparam int REG_AW = 5;
  localparam int XLEN   = 64;
  localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin picker, one-hot grant
module rr_arbiter #(
  parameter int N  = 2,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt
);

  int idx;
  logic found;

  // Scan from ptr upward with wraparound; the first active request wins.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - round-robin sharing of the register-file write port with hazard flags
module regfile_wb_arbiter
  import cpu_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int DW   = XLEN,
  parameter int AW   = REG_AW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hold,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*AW-1:0] req_rd,
  input  logic [NREQ*DW-1:0] req_data,
  output logic              reg_write,
  output logic [AW-1:0]     write_reg,
  output logic [DW-1:0]     write_data,
  input  logic [AW-1:0]     read_reg1,
  input  logic [AW-1:0]     read_reg2,
  output logic              hazard1,
  output logic              hazard2
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
  logic            reg_write_q, reg_write_d;
  logic [AW-1:0]   write_reg_q, write_reg_d;
  logic [DW-1:0]   write_data_q, write_data_d;
  logic [NREQ-1:0] gnt;
  logic            any_gnt;
  logic [PW-1:0]   winner;
  logic [AW-1:0]   win_rd;
  logic [DW-1:0]   win_data;

  rr_arbiter #(.N(NREQ), .PW(PW)) u_rr (
    .req (req_valid),
    .ptr (rr_ptr_q),
    .gnt (gnt)
  );

  // Ready is suppressed during freeze and while reset is asserted.
  assign req_ready = (rst_n && !hold) ? gnt : '0;
  assign any_gnt   = |req_ready;

  // Encode the one-hot winner and select its destination and data.
  always_comb begin
    winner   = '0;
    win_rd   = '0;
    win_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (req_ready[i]) begin
        winner   = PW'(i);
        win_rd   = req_rd[i*AW +: AW];
        win_data = req_data[i*DW +: DW];
      end
    end
  end

  // Next state: pointer moves past the winner; x0 writes load the stage but never assert the enable.
  always_comb begin
    rr_ptr_d     = rr_ptr_q;
    reg_write_d  = 1'b0;
    write_reg_d  = write_reg_q;
    write_data_d = write_data_q;
    if (any_gnt) begin
      rr_ptr_d     = (winner == PW'(NREQ - 1)) ? '0 : winner + 1'b1;
      reg_write_d  = (win_rd != REG_ZERO);
      write_reg_d  = win_rd;
      write_data_d = win_data;
    end
  end

  // Output stage and pointer registers, cleared immediately on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q     <= '0;
      reg_write_q  <= 1'b0;
      write_reg_q  <= '0;
      write_data_q <= '0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      reg_write_q  <= reg_write_d;
      write_reg_q  <= write_reg_d;
      write_data_q <= write_data_d;
    end
  end

  assign reg_write  = reg_write_q;
  assign write_reg  = write_reg_q;
  assign write_data = write_data_q;

  // Flag any read port whose register is pending in the output stage or at a requester.
  always_comb begin
    hazard1 = reg_write_q && (write_reg_q == read_reg1);
    hazard2 = reg_write_q && (write_reg_q == read_reg2);
    for (int i = 0; i < NREQ; i++) begin
      if (req_valid[i] && (req_rd[i*AW +: AW] == read_reg1)) hazard1 = 1'b1;
      if (req_valid[i] && (req_rd[i*AW +: AW] == read_reg2)) hazard2 = 1'b1;
    end
    if (read_reg1 == REG_ZERO) hazard1 = 1'b0;
    if (read_reg2 == REG_ZERO) hazard2 = 1'b0;
  end

endmodule
